// File: rtl/cap_prop_vector_sequencer.sv
// cap_prop_vector_sequencer
// Generates (base, len, addr) stimulus tuples for the cap-property checkers:
// a 64-entry corner sweep followed by NUM_RANDOM LFSR-derived tuples. Each
// accepted tuple is queued until its in-order verdict arrives. Verdicts are
// tallied, and the first failing tuple is captured for debug.
module cap_prop_vector_sequencer #(
  parameter int unsigned NUM_RANDOM = 1024,
  parameter logic [63:0] LFSR_SEED  = 64'h5EED_CAFE_1234_ABCD,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic [63:0] vec_base,
  output logic [63:0] vec_len,
  output logic [63:0] vec_addr,
  input  logic        res_valid,
  input  logic        res_ok,
  output logic        busy,
  output logic        done,
  output logic [31:0] sent_count,
  output logic [31:0] pass_count,
  output logic [31:0] fail_count,
  output logic        fail_seen,
  output logic [63:0] fail_base,
  output logic [63:0] fail_len,
  output logic [63:0] fail_addr,
  output logic        proto_err
);

  localparam int unsigned        PTR_W     = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned        OCNT_W    = PTR_W + 1;
  localparam logic [63:0]        LFSR_MASK = 64'hD800_0000_0000_0000;
  localparam logic [31:0]        LAST_RND  = 32'(NUM_RANDOM - 1);
  localparam logic [OCNT_W-1:0]  OUTST_MAX = OCNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_CORNER, S_RANDOM, S_DONE} state_e;

  // Corner values swept for both base and len.
  function automatic logic [63:0] corner_val(input logic [2:0] idx);
    logic [63:0] v;
    case (idx)
      3'd0:    v = 64'h0000_0000_0000_0000;
      3'd1:    v = 64'h0000_0000_0000_0001;
      3'd2:    v = 64'h0000_0000_0000_0FFF;
      3'd3:    v = 64'h0000_0000_0000_1000;
      3'd4:    v = 64'h7FFF_FFFF_FFFF_FFFF;
      3'd5:    v = 64'h8000_0000_0000_0000;
      3'd6:    v = 64'hFFFF_FFFF_FFFF_FFFE;
      default: v = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return v;
  endfunction

  // Corner tuples probe the midpoint of the region.
  function automatic logic [63:0] corner_addr(input logic [63:0] b, input logic [63:0] l);
    return b + (l >> 1);
  endfunction

  // Random len: rotr(L,21) shifted right by L[5:0], spreading lengths over all magnitudes.
  function automatic logic [63:0] rnd_len(input logic [63:0] l);
    logic [63:0] r21;
    r21 = {l[20:0], l[63:21]};
    return r21 >> l[5:0];
  endfunction

  // Random addr: base plus an offset masked to lie within len's bit pattern.
  function automatic logic [63:0] rnd_addr(input logic [63:0] l);
    logic [63:0] r42;
    r42 = {l[41:0], l[63:42]};
    return l + (r42 & rnd_len(l));
  endfunction

  // Galois right-shift LFSR step.
  function automatic logic [63:0] lfsr_step(input logic [63:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_MASK) : (l >> 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          i_q, i_d, j_q, j_d;
  logic [63:0]         lfsr_q, lfsr_d;
  logic [31:0]         rnd_cnt_q, rnd_cnt_d;
  logic [63:0]         vec_base_q, vec_base_d, vec_len_q, vec_len_d, vec_addr_q, vec_addr_d;
  logic [63:0]         fifo_base_q [MAX_OUTST];
  logic [63:0]         fifo_base_d [MAX_OUTST];
  logic [63:0]         fifo_len_q  [MAX_OUTST];
  logic [63:0]         fifo_len_d  [MAX_OUTST];
  logic [63:0]         fifo_addr_q [MAX_OUTST];
  logic [63:0]         fifo_addr_d [MAX_OUTST];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCNT_W-1:0]   outst_q, outst_d;
  logic [31:0]         sent_count_q, sent_count_d, pass_count_q, pass_count_d;
  logic [31:0]         fail_count_q, fail_count_d;
  logic                fail_seen_q, fail_seen_d, proto_err_q, proto_err_d;
  logic [63:0]         fail_base_q, fail_base_d, fail_len_q, fail_len_d, fail_addr_q, fail_addr_d;

  logic                start_ok;
  logic                gen_active;
  logic                xfer;
  logic                pop;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: corner sweep, then random phase, then wait for restart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_CORNER;
      S_CORNER: if (xfer && (i_q == 3'd7) && (j_q == 3'd7)) state_d = S_RANDOM;
      S_RANDOM: if (xfer && (rnd_cnt_q == LAST_RND)) state_d = S_DONE;
      S_DONE:   if (start_ok) state_d = S_CORNER;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs and handshake qualifiers; start only counts when nothing is in flight.
  always_comb begin
    gen_active = (state_q == S_CORNER) || (state_q == S_RANDOM);
    vec_valid  = gen_active && (outst_q < OUTST_MAX);
    busy       = gen_active || (outst_q != '0);
    done       = (state_q == S_DONE) && (outst_q == '0);
    start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE)) && (outst_q == '0);
    xfer       = vec_valid && vec_ready;
    pop        = res_valid && (outst_q != '0);
  end

  // Tuple generator: the next tuple is computed and registered on start or on each transfer.
  always_comb begin
    i_d        = i_q;
    j_d        = j_q;
    lfsr_d     = lfsr_q;
    rnd_cnt_d  = rnd_cnt_q;
    vec_base_d = vec_base_q;
    vec_len_d  = vec_len_q;
    vec_addr_d = vec_addr_q;
    if (start_ok) begin
      i_d        = 3'd0;
      j_d        = 3'd0;
      lfsr_d     = LFSR_SEED;
      rnd_cnt_d  = 32'd0;
      vec_base_d = corner_val(3'd0);
      vec_len_d  = corner_val(3'd0);
      vec_addr_d = corner_addr(corner_val(3'd0), corner_val(3'd0));
    end else if (xfer && (state_q == S_CORNER)) begin
      if (j_q == 3'd7) begin
        j_d = 3'd0;
        i_d = i_q + 3'd1;
      end else begin
        j_d = j_q + 3'd1;
      end
      if ((i_q == 3'd7) && (j_q == 3'd7)) begin
        // First random tuple is taken from the LFSR value before any step.
        vec_base_d = lfsr_q;
        vec_len_d  = rnd_len(lfsr_q);
        vec_addr_d = rnd_addr(lfsr_q);
      end else begin
        vec_base_d = corner_val(i_d);
        vec_len_d  = corner_val(j_d);
        vec_addr_d = corner_addr(corner_val(i_d), corner_val(j_d));
      end
    end else if (xfer && (state_q == S_RANDOM)) begin
      lfsr_d    = lfsr_step(lfsr_q);
      rnd_cnt_d = rnd_cnt_q + 32'd1;
      if (rnd_cnt_q == LAST_RND) begin
        vec_base_d = '0;
        vec_len_d  = '0;
        vec_addr_d = '0;
      end else begin
        vec_base_d = lfsr_d;
        vec_len_d  = rnd_len(lfsr_d);
        vec_addr_d = rnd_addr(lfsr_d);
      end
    end
  end

  // Outstanding queue, verdict accounting and first-failure capture.
  always_comb begin
    fifo_base_d  = fifo_base_q;
    fifo_len_d   = fifo_len_q;
    fifo_addr_d  = fifo_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    outst_d      = outst_q;
    sent_count_d = sent_count_q;
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;
    fail_seen_d  = fail_seen_q;
    fail_base_d  = fail_base_q;
    fail_len_d   = fail_len_q;
    fail_addr_d  = fail_addr_q;
    proto_err_d  = proto_err_q;
    // start is only accepted with an empty queue, so it never coincides with push or pop.
    if (start_ok) begin
      sent_count_d = 32'd0;
      pass_count_d = 32'd0;
      fail_count_d = 32'd0;
      fail_seen_d  = 1'b0;
      fail_base_d  = '0;
      fail_len_d   = '0;
      fail_addr_d  = '0;
      proto_err_d  = 1'b0;
    end
    if (xfer) begin
      fifo_base_d[wr_ptr_q] = vec_base_q;
      fifo_len_d[wr_ptr_q]  = vec_len_q;
      fifo_addr_d[wr_ptr_q] = vec_addr_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      sent_count_d          = sat_inc(sent_count_q);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (res_ok) begin
        pass_count_d = sat_inc(pass_count_q);
      end else begin
        fail_count_d = sat_inc(fail_count_q);
        if (!fail_seen_q) begin
          fail_seen_d = 1'b1;
          fail_base_d = fifo_base_q[rd_ptr_q];
          fail_len_d  = fifo_len_q[rd_ptr_q];
          fail_addr_d = fifo_addr_q[rd_ptr_q];
        end
      end
    end
    if (res_valid && (outst_q == '0)) proto_err_d = 1'b1;
    case ({xfer, pop})
      2'b10:   outst_d = outst_q + OCNT_W'(1);
      2'b01:   outst_d = outst_q - OCNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Datapath and bookkeeping registers; reset clears everything and reloads the seed.
  always_ff @(posedge CLK) begin
    if (RST) begin
      i_q          <= '0;
      j_q          <= '0;
      lfsr_q       <= LFSR_SEED;
      rnd_cnt_q    <= '0;
      vec_base_q   <= '0;
      vec_len_q    <= '0;
      vec_addr_q   <= '0;
      for (int k = 0; k < MAX_OUTST; k++) begin
        fifo_base_q[k] <= '0;
        fifo_len_q[k]  <= '0;
        fifo_addr_q[k] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      outst_q      <= '0;
      sent_count_q <= '0;
      pass_count_q <= '0;
      fail_count_q <= '0;
      fail_seen_q  <= 1'b0;
      fail_base_q  <= '0;
      fail_len_q   <= '0;
      fail_addr_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      i_q          <= i_d;
      j_q          <= j_d;
      lfsr_q       <= lfsr_d;
      rnd_cnt_q    <= rnd_cnt_d;
      vec_base_q   <= vec_base_d;
      vec_len_q    <= vec_len_d;
      vec_addr_q   <= vec_addr_d;
      fifo_base_q  <= fifo_base_d;
      fifo_len_q   <= fifo_len_d;
      fifo_addr_q  <= fifo_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      outst_q      <= outst_d;
      sent_count_q <= sent_count_d;
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
      fail_seen_q  <= fail_seen_d;
      fail_base_q  <= fail_base_d;
      fail_len_q   <= fail_len_d;
      fail_addr_q  <= fail_addr_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign vec_base   = vec_base_q;
  assign vec_len    = vec_len_q;
  assign vec_addr   = vec_addr_q;
  assign sent_count = sent_count_q;
  assign pass_count = pass_count_q;
  assign fail_count = fail_count_q;
  assign fail_seen  = fail_seen_q;
  assign fail_base  = fail_base_q;
  assign fail_len   = fail_len_q;
  assign fail_addr  = fail_addr_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_cap_prop_vector_sequencer.sv
// Directed bench for cap_prop_vector_sequencer with hand-computed tuples.
module tb_cap_prop_vector_sequencer;

  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] HALF_LO = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST, start, vec_ready, res_valid, res_ok;
  logic        vec_valid, busy, done, fail_seen, proto_err;
  logic [63:0] vec_base, vec_len, vec_addr, fail_base, fail_len, fail_addr;
  logic [31:0] sent_count, pass_count, fail_count;

  int   vectors = 0;
  int   miscompares = 0;
  int   tb_sent;
  int   prev_idx;
  int   budget;
  logic xfer_prev;
  logic xfer_now;

  cap_prop_vector_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_base(vec_base), .vec_len(vec_len), .vec_addr(vec_addr),
    .res_valid(res_valid), .res_ok(res_ok),
    .busy(busy), .done(done),
    .sent_count(sent_count), .pass_count(pass_count), .fail_count(fail_count),
    .fail_seen(fail_seen), .fail_base(fail_base), .fail_len(fail_len), .fail_addr(fail_addr),
    .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tuple(input string tag, input logic [63:0] b, input logic [63:0] l,
                           input logic [63:0] a);
    chk({tag, "_base"}, vec_base, b);
    chk({tag, "_len"},  vec_len,  l);
    chk({tag, "_addr"}, vec_addr, a);
  endtask

  task automatic check_tuple(input int idx);
    case (idx)
      0:  chk_tuple("t0",  64'h0, 64'h0, 64'h0);
      3:  chk_tuple("t3",  64'h0, 64'h1000, 64'h800);
      7:  chk_tuple("t7",  64'h0, ONES, HALF_LO);
      9:  chk_tuple("t9",  64'h1, 64'h1, 64'h1);
      10: chk_tuple("t10", 64'h1, 64'hFFF, 64'h800);
      63: chk_tuple("t63", ONES, ONES, 64'h7FFF_FFFF_FFFF_FFFE);
      64: chk_tuple("t64", 64'h5EED_CAFE_1234_ABCD, 64'h0005_2AF3_57BB_72BF,
                    64'h5EF1_D320_6547_DDFF);
      default: ;
    endcase
  endtask

  // One cycle at the negedge: answer last cycle's transfer, then observe this cycle's.
  task automatic cycle(input logic rdy);
    vec_ready = rdy;
    res_valid = xfer_prev;
    res_ok    = !((prev_idx == 3) || (prev_idx == 7));
    xfer_now  = vec_valid && rdy;
    if (xfer_now) begin
      check_tuple(tb_sent);
      prev_idx = tb_sent;
      tb_sent++;
    end
    xfer_prev = xfer_now;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; vec_ready = 1'b0; res_valid = 1'b0; res_ok = 1'b0;
    xfer_prev = 1'b0; xfer_now = 1'b0; prev_idx = -1; tb_sent = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Reset state
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_count, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_fail_seen", fail_seen, 0);
    chk("rst_vec_base", vec_base, 0);
    chk("rst_proto_err", proto_err, 0);

    // Verdict while idle
    res_valid = 1'b1; res_ok = 1'b1;
    @(posedge CLK); @(negedge CLK);
    res_valid = 1'b0;
    chk("idle_proto_err", proto_err, 1);
    chk("idle_pass", pass_count, 0);
    chk("idle_fail", fail_count, 0);

    // Run 1: full sweep, fails on tuples 3 and 7, stall at tuple 10
    start = 1'b1; vec_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    chk("start_proto_clr", proto_err, 0);
    chk("start_vec_valid", vec_valid, 1);
    chk("start_busy", busy, 1);
    chk("start_sent", sent_count, 0);

    budget = 0;
    while (tb_sent < 10 && budget < 200) begin cycle(1'b1); budget++; end
    chk("pre_stall_sent", sent_count, 10);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0);
      chk("stall_valid", vec_valid, 1);
      chk_tuple("stall", 64'h1, 64'hFFF, 64'h800);
      chk("stall_sent", sent_count, 10);
    end

    budget = 0;
    while (!done && budget < 5000) begin cycle(1'b1); budget++; end
    chk("run1_done", done, 1);
    chk("run1_sent", sent_count, 1088);
    chk("run1_pass", pass_count, 1086);
    chk("run1_fail", fail_count, 2);
    chk("run1_fail_seen", fail_seen, 1);
    chk("run1_fail_base", fail_base, 64'h0);
    chk("run1_fail_len", fail_len, 64'h1000);
    chk("run1_fail_addr", fail_addr, 64'h800);
    chk("run1_busy", busy, 0);
    chk("run1_vec_valid", vec_valid, 0);
    chk("run1_vec_base", vec_base, 0);
    chk("run1_proto_err", proto_err, 0);

    // Run 2: outstanding limit with verdicts withheld
    start = 1'b1; vec_ready = 1'b1; res_valid = 1'b0;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    chk("run2_sent_clr", sent_count, 0);
    chk("run2_fail_clr", fail_count, 0);
    chk("run2_fail_seen_clr", fail_seen, 0);
    chk("run2_fail_base_clr", fail_base, 0);
    chk("run2_valid", vec_valid, 1);
    repeat (4) begin @(posedge CLK); @(negedge CLK); end
    chk("full_valid", vec_valid, 0);
    chk("full_sent", sent_count, 4);
    @(posedge CLK); @(negedge CLK);
    chk("full_valid_hold", vec_valid, 0);
    chk("full_sent_hold", sent_count, 4);
    chk("full_busy", busy, 1);
    res_valid = 1'b1; res_ok = 1'b1;
    @(posedge CLK); @(negedge CLK);
    res_valid = 1'b0;
    chk("reopen_valid", vec_valid, 1);
    chk("reopen_pass", pass_count, 1);
    chk("reopen_t4_len", vec_len, HALF_LO);
    chk("reopen_t4_addr", vec_addr, 64'h3FFF_FFFF_FFFF_FFFF);
    // Push and pop in the same cycle
    res_valid = 1'b1; res_ok = 1'b1; vec_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    res_valid = 1'b0; vec_ready = 1'b0;
    chk("pushpop_sent", sent_count, 5);
    chk("pushpop_pass", pass_count, 2);
    chk("pushpop_valid", vec_valid, 1);
    chk("pushpop_t5_len", vec_len, 64'h8000_0000_0000_0000);

    // Advance into the random phase, then reset mid-run
    tb_sent = 5; xfer_prev = 1'b0; prev_idx = -1;
    budget = 0;
    while (tb_sent < 70 && budget < 1000) begin cycle(1'b1); budget++; end
    chk("mid_random_sent", sent_count, 70);
    RST = 1'b1; res_valid = 1'b0;
    @(posedge CLK); @(negedge CLK);
    chk("midrst_vec_valid", vec_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sent", sent_count, 0);
    chk("midrst_pass", pass_count, 0);
    chk("midrst_fail", fail_count, 0);
    chk("midrst_fail_seen", fail_seen, 0);
    chk("midrst_fail_addr", fail_addr, 0);
    chk("midrst_vec_base", vec_base, 0);
    chk("midrst_vec_addr", vec_addr, 0);
    chk("midrst_proto_err", proto_err, 0);
    RST = 1'b0;

    // Restart from the beginning of the sweep
    start = 1'b1; vec_ready = 1'b0;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    chk("restart_valid", vec_valid, 1);
    tb_sent = 0; xfer_prev = 1'b0; prev_idx = -1;
    budget = 0;
    while (tb_sent < 2 && budget < 20) begin cycle(1'b1); budget++; end
    chk("restart_t2_len", vec_len, 64'hFFF);
    chk("restart_t2_addr", vec_addr, 64'h7FF);
    chk("restart_sent", sent_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
